// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the decode stage:
//   - default widths of the instruction word and its fields
//   - helper functions that locate each field for any width choice
//   - field offsets for the default widths
//   - decoded_t, the decoded-instruction record at the default widths
// No ports: this is a package, imported with "import proc_pkg::*".
// -----------------------------------------------------------------------------
package proc_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int REG_AW_DEF  = 6;
  localparam int OP_W_DEF    = 4;
  localparam int IMM_W_DEF   = 15;

  // Field layout, MSB down: imm_sel, rs, rd, aluop, rt.
  // The immediate sits at the bottom of the word and may overlap rt.
  function automatic int rsLsb(input int instrW, input int regAw);
    return instrW - 1 - regAw;
  endfunction

  function automatic int rdLsb(input int instrW, input int regAw);
    return instrW - 1 - 2 * regAw;
  endfunction

  function automatic int opLsb(input int instrW, input int regAw, input int opW);
    return instrW - 1 - 2 * regAw - opW;
  endfunction

  function automatic int rtLsb(input int instrW, input int regAw, input int opW);
    return instrW - 1 - 3 * regAw - opW;
  endfunction

  // Widest immediate that still fits below the aluop field.
  function automatic int immRoom(input int instrW, input int regAw, input int opW);
    return instrW - 1 - 2 * regAw - opW;
  endfunction

  localparam int IMMSEL_POS = INSTR_W_DEF - 1;
  localparam int RS_LSB     = rsLsb(INSTR_W_DEF, REG_AW_DEF);
  localparam int RD_LSB     = rdLsb(INSTR_W_DEF, REG_AW_DEF);
  localparam int OP_LSB     = opLsb(INSTR_W_DEF, REG_AW_DEF, OP_W_DEF);
  localparam int RT_LSB     = rtLsb(INSTR_W_DEF, REG_AW_DEF, OP_W_DEF);

  typedef struct packed {
    logic                  imm_sel;
    logic [REG_AW_DEF-1:0] rs;
    logic [REG_AW_DEF-1:0] rd;
    logic [OP_W_DEF-1:0]   aluop;
    logic [REG_AW_DEF-1:0] rt;
    logic [IMM_W_DEF-1:0]  imm;
    logic                  regwrite;
  } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
// Bundles the decode stage's handshake and data signals.
//   Instruction side : in_valid, in_ready, in_instr, flush
//   Writeback side   : wb_valid, wb_rd
//   Decoded side     : out_valid, out_ready, out_imm_sel, out_rs, out_rd,
//                      out_rt, out_aluop, out_imm, out_regwrite
// Modports:
//   master - the surrounding pipeline (drives instructions, writebacks, out_ready)
//   slave  - the decode stage itself
// -----------------------------------------------------------------------------
interface decode_stage_if
  import proc_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int IMM_W   = IMM_W_DEF
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               wb_valid;
  logic [REG_AW-1:0]  wb_rd;
  logic               out_valid;
  logic               out_ready;
  logic               out_imm_sel;
  logic [REG_AW-1:0]  out_rs;
  logic [REG_AW-1:0]  out_rd;
  logic [REG_AW-1:0]  out_rt;
  logic [OP_W-1:0]    out_aluop;
  logic [IMM_W-1:0]   out_imm;
  logic               out_regwrite;

  modport master (
    output in_valid, in_instr, flush, wb_valid, wb_rd, out_ready,
    input  in_ready, out_valid, out_imm_sel, out_rs, out_rd, out_rt,
           out_aluop, out_imm, out_regwrite
  );

  modport slave (
    input  in_valid, in_instr, flush, wb_valid, wb_rd, out_ready,
    output in_ready, out_valid, out_imm_sel, out_rs, out_rd, out_rt,
           out_aluop, out_imm, out_regwrite
  );

endinterface

// File: rtl/decode_scoreboard.sv
// -----------------------------------------------------------------------------
// decode_scoreboard
// Busy table (one bit per architectural register) and the read/write hazard
// check for the instruction currently offered to the decode stage.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   wbValid_i    - writeback completes this cycle
//   wbRd_i       - register whose busy bit the writeback clears
//   outValid_i   - decode output register holds an instruction
//   take_i       - downstream takes the held instruction this cycle
//   flush_i      - held instruction is being discarded
//   outRd_i      - destination of the held instruction
//   immSel_i     - offered instruction uses the immediate instead of rt
//   rs_i/rd_i/rt_i - register fields of the offered instruction
//   hazard_o     - offered instruction must wait
// -----------------------------------------------------------------------------
module decode_scoreboard #(
  parameter int REG_AW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbValid_i,
  input  logic [REG_AW-1:0] wbRd_i,
  input  logic              outValid_i,
  input  logic              take_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] outRd_i,
  input  logic              immSel_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rt_i,
  output logic              hazard_o
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] wbMask;
  logic [NREG-1:0] holdMask;
  logic [NREG-1:0] pending;

  // A register counts as pending if it is busy and not being written back
  // right now, or if it is the destination of the instruction still sitting
  // in the output register. Writing the clear first and the set second makes
  // a same-cycle take win over a writeback to the same register. A flushed
  // instruction never reaches the table.
  always_comb begin
    wbMask   = '0;
    holdMask = '0;
    if (wbValid_i) begin
      wbMask[wbRd_i] = 1'b1;
    end
    if (outValid_i && !take_i) begin
      holdMask[outRd_i] = 1'b1;
    end
    pending = (busy_q & ~wbMask) | holdMask;

    busy_d = busy_q & ~wbMask;
    if (take_i && !flush_i) begin
      busy_d[outRd_i] = 1'b1;
    end

    hazard_o = pending[rs_i] | pending[rd_i] | (~immSel_i & pending[rt_i]);
  end

  // Busy table state; reset clears every register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// One-deep registered instruction decoder with valid/ready handshakes on both
// sides. Splits the raw word into imm_sel, rs, rd, aluop, rt and imm and holds
// the result until downstream takes it.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - decode_stage_if.slave (instruction, writeback, decoded handshakes)
// Configuration:
//   DECODE_SCOREBOARD_EN - when defined, a busy table stalls instructions that
//   touch registers with writes still outstanding. When undefined, the stage
//   never stalls on registers and ignores the writeback inputs.
// -----------------------------------------------------------------------------
module decode_stage
  import proc_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int IMM_W   = IMM_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  localparam int RS_L = rsLsb(INSTR_W, REG_AW);
  localparam int RD_L = rdLsb(INSTR_W, REG_AW);
  localparam int OP_L = opLsb(INSTR_W, REG_AW, OP_W);
  localparam int RT_L = rtLsb(INSTR_W, REG_AW, OP_W);

  // An immediate wider than the space under aluop would alias the opcode.
  if (IMM_W > immRoom(INSTR_W, REG_AW, OP_W)) begin : gImmTooWide
    $error("decode_stage: IMM_W does not fit below the aluop field");
  end

  logic              inImmSel;
  logic [REG_AW-1:0] inRs;
  logic [REG_AW-1:0] inRd;
  logic [REG_AW-1:0] inRt;
  logic [OP_W-1:0]   inAluop;
  logic [IMM_W-1:0]  inImm;

  logic hazard;
  logic inReady;
  logic accept;
  logic take;

  logic              outValid_q,    outValid_d;
  logic              outImmSel_q,   outImmSel_d;
  logic [REG_AW-1:0] outRs_q,       outRs_d;
  logic [REG_AW-1:0] outRd_q,       outRd_d;
  logic [REG_AW-1:0] outRt_q,       outRt_d;
  logic [OP_W-1:0]   outAluop_q,    outAluop_d;
  logic [IMM_W-1:0]  outImm_q,      outImm_d;
  logic              outRegwrite_q, outRegwrite_d;

  // Field extraction from the word currently offered upstream.
  assign inImmSel = bus.in_instr[INSTR_W-1];
  assign inRs     = bus.in_instr[RS_L +: REG_AW];
  assign inRd     = bus.in_instr[RD_L +: REG_AW];
  assign inAluop  = bus.in_instr[OP_L +: OP_W];
  assign inRt     = bus.in_instr[RT_L +: REG_AW];
  assign inImm    = bus.in_instr[IMM_W-1:0];

  // Ready when the output slot is free or being emptied, and nothing blocks.
  assign inReady = (~outValid_q | bus.out_ready) & ~hazard & ~bus.flush;
  assign accept  = bus.in_valid & inReady;
  assign take    = outValid_q & bus.out_ready;

`ifdef DECODE_SCOREBOARD_EN
  decode_scoreboard #(
    .REG_AW(REG_AW)
  ) uScoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wbValid_i  (bus.wb_valid),
    .wbRd_i     (bus.wb_rd),
    .outValid_i (outValid_q),
    .take_i     (take),
    .flush_i    (bus.flush),
    .outRd_i    (outRd_q),
    .immSel_i   (inImmSel),
    .rs_i       (inRs),
    .rd_i       (inRd),
    .rt_i       (inRt),
    .hazard_o   (hazard)
  );
`else
  logic unusedWb;
  assign hazard   = 1'b0;
  assign unusedWb = ^{bus.wb_valid, bus.wb_rd};
`endif

  // Output slot next state: flush empties it, an accept loads a freshly
  // decoded word, a take empties it, otherwise everything holds. Data fields
  // only change on accept so they stay stable while waiting downstream.
  always_comb begin
    outValid_d    = outValid_q;
    outImmSel_d   = outImmSel_q;
    outRs_d       = outRs_q;
    outRd_d       = outRd_q;
    outRt_d       = outRt_q;
    outAluop_d    = outAluop_q;
    outImm_d      = outImm_q;
    outRegwrite_d = outRegwrite_q;
    if (bus.flush) begin
      outValid_d = 1'b0;
    end else if (accept) begin
      outValid_d    = 1'b1;
      outImmSel_d   = inImmSel;
      outRs_d       = inRs;
      outRd_d       = inRd;
      outRt_d       = inRt;
      outAluop_d    = inAluop;
      outImm_d      = inImm;
      outRegwrite_d = 1'b1;
    end else if (take) begin
      outValid_d = 1'b0;
    end
  end

  // Output slot registers; reset clears valid and zeroes every data field so
  // nothing downstream ever sees X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid_q    <= 1'b0;
      outImmSel_q   <= 1'b0;
      outRs_q       <= '0;
      outRd_q       <= '0;
      outRt_q       <= '0;
      outAluop_q    <= '0;
      outImm_q      <= '0;
      outRegwrite_q <= 1'b0;
    end else begin
      outValid_q    <= outValid_d;
      outImmSel_q   <= outImmSel_d;
      outRs_q       <= outRs_d;
      outRd_q       <= outRd_d;
      outRt_q       <= outRt_d;
      outAluop_q    <= outAluop_d;
      outImm_q      <= outImm_d;
      outRegwrite_q <= outRegwrite_d;
    end
  end

  assign bus.in_ready     = inReady;
  assign bus.out_valid    = outValid_q;
  assign bus.out_imm_sel  = outImmSel_q;
  assign bus.out_rs       = outRs_q;
  assign bus.out_rd       = outRd_q;
  assign bus.out_rt       = outRt_q;
  assign bus.out_aluop    = outAluop_q;
  assign bus.out_imm      = outImm_q;
  assign bus.out_regwrite = outRegwrite_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage: a table of known instruction words,
// hand-written multi-cycle sequences (stall, hazard, flush, reset) and a
// randomized run, all compared against a behavioural model of the stage.
// The scoreboard-specific expectations follow DECODE_SCOREBOARD_EN.
// -----------------------------------------------------------------------------
module tb_decode_stage;
  import proc_pkg::*;

  typedef struct {
    bit          rstN;
    bit          inValid;
    logic [31:0] instr;
    bit          outReady;
    bit          flush;
    bit          wbValid;
    logic [5:0]  wbRd;
  } stim_t;

  typedef struct {
    logic [31:0] instr;
    decoded_t    exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit checkEnable = 1'b0;

  // Behavioural model state: the held decoded word and per-register busy flags.
  bit          mValid;
  decoded_t    mOut;
  bit [63:0]   mBusy;

  vec_t vecs[7];

  // Decode a word straight from the field map with plain arithmetic.
  function automatic decoded_t decodeRef(input logic [31:0] w);
    decoded_t    d;
    int unsigned u;
    u          = w;
    d.imm_sel  = 1'((u >> 31) % 2);
    d.rs       = 6'((u >> 25) % 64);
    d.rd       = 6'((u >> 19) % 64);
    d.aluop    = 4'((u >> 15) % 16);
    d.rt       = 6'((u >> 9) % 64);
    d.imm      = 15'(u % 32768);
    d.regwrite = 1'b1;
    return d;
  endfunction

  function automatic decoded_t actualOut();
    decoded_t a;
    a.imm_sel  = bus.out_imm_sel;
    a.rs       = bus.out_rs;
    a.rd       = bus.out_rd;
    a.aluop    = bus.out_aluop;
    a.rt       = bus.out_rt;
    a.imm      = bus.out_imm;
    a.regwrite = bus.out_regwrite;
    return a;
  endfunction

  // A register waits if its write is outstanding and not retiring this cycle,
  // or if the instruction still parked at the output (not leaving) writes it.
  function automatic bit isPending(input int r);
`ifdef DECODE_SCOREBOARD_EN
    bit p;
    p = mBusy[r] && !(bus.wb_valid && int'(bus.wb_rd) == r);
    if (mValid && !bus.out_ready && int'(mOut.rd) == r) p = 1'b1;
    return p;
`else
    return (r < 0);
`endif
  endfunction

  function automatic bit modelReady();
    decoded_t d;
    bit       haz;
    d   = decodeRef(bus.in_instr);
    haz = isPending(int'(d.rs)) || isPending(int'(d.rd)) ||
          (!d.imm_sel && isPending(int'(d.rt)));
    return (!mValid || bus.out_ready) && !haz && !bus.flush;
  endfunction

  function automatic stim_t mk(input bit rstN, input bit inValid,
                               input logic [31:0] instr, input bit outReady,
                               input bit flush = 1'b0, input bit wbValid = 1'b0,
                               input logic [5:0] wbRd = 6'd0);
    stim_t s;
    s.rstN = rstN; s.inValid = inValid; s.instr = instr; s.outReady = outReady;
    s.flush = flush; s.wbValid = wbValid; s.wbRd = wbRd;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    if (!checkEnable) return;
    if (rst_n) checkOutput("in_ready", 64'(bus.in_ready), 64'(modelReady()));
    checkOutput("out_valid", 64'(bus.out_valid), 64'(mValid));
    checkOutput("fields", 64'(actualOut()), 64'(mOut));
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelAdvance();
    bit ready, take, accept;
    if (!rst_n) begin
      mValid = 1'b0;
      mOut   = '0;
      mBusy  = '0;
      return;
    end
    ready  = modelReady();
    take   = mValid && bus.out_ready;
    accept = bus.in_valid && ready;
`ifdef DECODE_SCOREBOARD_EN
    if (bus.wb_valid) mBusy[bus.wb_rd] = 1'b0;
    if (take && !bus.flush) mBusy[mOut.rd] = 1'b1;
`endif
    if (bus.flush) mValid = 1'b0;
    else if (accept) begin
      mValid = 1'b1;
      mOut   = decodeRef(bus.in_instr);
    end else if (take) mValid = 1'b0;
  endtask

  // Drive one cycle of inputs (called just after a rising edge), compare
  // against the model mid-cycle, then step to just after the next edge.
  task automatic applyStimulus(input stim_t s);
    rst_n         = s.rstN;
    bus.in_valid  = s.inValid;
    bus.in_instr  = s.instr;
    bus.out_ready = s.outReady;
    bus.flush     = s.flush;
    bus.wb_valid  = s.wbValid;
    bus.wb_rd     = s.wbRd;
    @(negedge clk);
    checkModel();
    modelAdvance();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    applyStimulus(mk(1'b0, 1'b0, 32'h0, 1'b0));
  endtask

  localparam logic [31:0] W_RD3  = 32'h9418_0000;  // imm_sel=1 rs=10 rd=3
  localparam logic [31:0] D_RS3  = 32'h8660_0000;  // imm_sel=1 rs=3 rd=12
  localparam logic [31:0] W_RD7  = 32'h8038_0000;  // imm_sel=1 rd=7
  localparam logic [31:0] E_IMM  = 32'h8210_0E00;  // imm_sel=1 rs=1 rd=2 rt=7
  localparam logic [31:0] E_REG  = 32'h0210_0E00;  // imm_sel=0 rs=1 rd=2 rt=7
  localparam logic [31:0] F_RD9  = 32'h8048_0000;  // imm_sel=1 rd=9
  localparam logic [31:0] G_RS9  = 32'h9200_0000;  // imm_sel=1 rs=9
  localparam logic [31:0] A_WORD = 32'h0211_8805;  // rs=1 rd=2 aluop=3 rt=4
  localparam logic [31:0] B_WORD = 32'h8A5A_8000;  // rs=5 rd=11 aluop=5

  initial begin
    vecs[0] = '{32'h8A5A_8000, '{1'b1, 6'd5,  6'd11, 4'd5,  6'd0,  15'h0000, 1'b1}};
    vecs[1] = '{32'h0000_0000, '{1'b0, 6'd0,  6'd0,  4'd0,  6'd0,  15'h0000, 1'b1}};
    vecs[2] = '{32'hFFFF_FFFF, '{1'b1, 6'd63, 6'd63, 4'd15, 6'd63, 15'h7FFF, 1'b1}};
    vecs[3] = '{32'h7FFF_FFFF, '{1'b0, 6'd63, 6'd63, 4'd15, 6'd63, 15'h7FFF, 1'b1}};
    vecs[4] = '{32'h0000_7FFF, '{1'b0, 6'd0,  6'd0,  4'd0,  6'd63, 15'h7FFF, 1'b1}};
    vecs[5] = '{32'h0211_8805, '{1'b0, 6'd1,  6'd2,  4'd3,  6'd4,  15'h0805, 1'b1}};
    vecs[6] = '{32'h8000_0001, '{1'b1, 6'd0,  6'd0,  4'd0,  6'd0,  15'h0001, 1'b1}};

    mValid = 1'b0; mOut = '0; mBusy = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
    bus.flush = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0;
    @(posedge clk);
    #2;

    // Reset state: outputs cleared, regwrite low until a word is loaded.
    doReset();
    checkEnable = 1'b1;
    doReset();
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_fields", 64'(actualOut()), 64'd0);

    // Table: each word decodes to its listed fields one edge after accept.
    for (int i = 0; i < 7; i++) begin
      doReset();
      applyStimulus(mk(1'b1, 1'b1, vecs[i].instr, 1'b1));
      checkOutput($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("vec%0d_fields", i), 64'(actualOut()), 64'(vecs[i].exp));
      applyStimulus(mk(1'b1, 1'b0, 32'h0, 1'b1));
      checkOutput($sformatf("vec%0d_taken", i), 64'(bus.out_valid), 64'd0);
    end

    // Back-pressure: a held word stays put for three cycles, then leaves once.
    doReset();
    applyStimulus(mk(1'b1, 1'b1, A_WORD, 1'b0));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(1'b1, 1'b1, B_WORD, 1'b0));
      checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("bp_hold", 64'(actualOut()), 64'(vecs[5].exp));
    end
    applyStimulus(mk(1'b1, 1'b1, B_WORD, 1'b1));
    checkOutput("bp_next_word", 64'(actualOut()), 64'(vecs[0].exp));
    checkOutput("bp_next_valid", 64'(bus.out_valid), 64'd1);
    applyStimulus(mk(1'b1, 1'b0, 32'h0, 1'b1));
    checkOutput("bp_drained", 64'(bus.out_valid), 64'd0);

    // Source register busy: stall until its writeback, accept in that cycle.
    doReset();
    applyStimulus(mk(1'b1, 1'b1, W_RD3, 1'b1));
    applyStimulus(mk(1'b1, 1'b0, 32'h0, 1'b1));
    applyStimulus(mk(1'b1, 1'b1, D_RS3, 1'b1));
    applyStimulus(mk(1'b1, 1'b1, D_RS3, 1'b1));
`ifdef DECODE_SCOREBOARD_EN
    checkOutput("raw_stalled", 64'(bus.out_valid), 64'd0);
    checkOutput("raw_in_ready", 64'(bus.in_ready), 64'd0);
`endif
    applyStimulus(mk(1'b1, 1'b1, D_RS3, 1'b0, 1'b0, 1'b1, 6'd3));
    checkOutput("raw_released", 64'(bus.out_valid), 64'd1);
    checkOutput("raw_rs", 64'(bus.out_rs), 64'd3);

    // rt only matters when the immediate is not selected.
    doReset();
    applyStimulus(mk(1'b1, 1'b1, W_RD7, 1'b1));
    applyStimulus(mk(1'b1, 1'b0, E_IMM, 1'b1));
    checkOutput("rt_imm_ready", 64'(bus.in_ready), 64'd1);
    applyStimulus(mk(1'b1, 1'b0, E_REG, 1'b1));
`ifdef DECODE_SCOREBOARD_EN
    checkOutput("rt_reg_stall", 64'(bus.in_ready), 64'd0);
`endif

    // Flush drops the held word and leaves its destination free.
    doReset();
    applyStimulus(mk(1'b1, 1'b1, F_RD9, 1'b0));
    checkOutput("flush_held", 64'(bus.out_valid), 64'd1);
    applyStimulus(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1));
    checkOutput("flush_dropped", 64'(bus.out_valid), 64'd0);
    applyStimulus(mk(1'b1, 1'b1, G_RS9, 1'b1));
    checkOutput("flush_rd_free", 64'(bus.out_valid), 64'd1);

    // Reset while holding a word with busy registers clears everything.
    doReset();
    applyStimulus(mk(1'b1, 1'b1, W_RD3, 1'b1));
    applyStimulus(mk(1'b1, 1'b1, F_RD9, 1'b0));
    applyStimulus(mk(1'b0, 1'b1, F_RD9, 1'b0));
    checkOutput("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_mid_fields", 64'(actualOut()), 64'd0);
    checkOutput("rst_mid_ready", 64'(bus.in_ready), 64'd1);
    applyStimulus(mk(1'b1, 1'b1, D_RS3, 1'b0));
    checkOutput("rst_busy_cleared", 64'(bus.out_valid), 64'd1);

    // Randomized traffic on a small register set to provoke hazards.
    doReset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] w;
      w = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)),
           6'($urandom_range(0, 3)), 4'($urandom), 6'($urandom_range(0, 3)),
           9'($urandom)};
      applyStimulus(mk($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), w,
                       1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                       $urandom_range(0, 2) == 0, 6'($urandom_range(0, 3))));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
